// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// grant encoding and the data word returned on an aborted access.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational two-way round-robin picker. On contention the port that did
// not win last time is chosen; a lone requester always wins.
module rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  // Pick the requester, alternating when both ask in the same cycle.
  always_comb begin
    grant_valid = req_i | req_d;
    grant       = GRANT_I;
    if (req_i && req_d) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester memory arbiter: shares one memory target between the
// instruction-side and data-side MMU ports, one transaction at a time.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to abort an access that is
// not acknowledged within TIMEOUT_CYCLES, returning BUS_ERR_DATA and setting
// the sticky err flag. Without it ACCESS waits indefinitely and err is 0.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        i_read_enable,
  input  logic        i_write_enable,
  input  logic [1:0]  i_data_width,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data_in,
  output logic [31:0] i_data_out,
  output logic        i_mem_ready,
  // data port
  input  logic        d_read_enable,
  input  logic        d_write_enable,
  input  logic [1:0]  d_data_width,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  output logic [31:0] d_data_out,
  output logic        d_mem_ready,
  // memory target
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ack,
  // status
  output logic        grant_d,
  output logic        err
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q;
  grant_t     grant_q;
  grant_t     pick_grant;
  logic       pick_valid;
  logic       timeout_hit;

  rr_picker u_rr_picker (
    .req_i       (i_read_enable | i_write_enable),
    .req_d       (d_read_enable | d_write_enable),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant       (pick_grant)
  );

  assign grant_d = (grant_q == GRANT_D);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;

  // An ack in the final allowed cycle still wins over the abort.
  assign timeout_hit = (state_q == ST_ACCESS) && !mem_ack && (tmo_cnt_q == TMO_LAST);
  assign err         = err_q;

  // Count ACCESS cycles (held at zero elsewhere) and latch the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_ACCESS) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                      tmo_cnt_q <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err                = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: sample requests only in IDLE, leave ACCESS on ack or abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Latch the winning request, hold it to the target, return data and pulse ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q   <= GRANT_I;
      grant_q        <= GRANT_I;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_data_width <= 2'd0;
      mem_address    <= 32'd0;
      mem_data_in    <= 32'd0;
      i_data_out     <= 32'd0;
      d_data_out     <= 32'd0;
      i_mem_ready    <= 1'b0;
      d_mem_ready    <= 1'b0;
    end else begin
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_grant;
            mem_req <= 1'b1;
            if (pick_grant == GRANT_D) begin
              mem_we         <= d_write_enable;
              mem_data_width <= d_data_width;
              mem_address    <= d_address;
              mem_data_in    <= d_data_in;
            end else begin
              mem_we         <= i_write_enable;
              mem_data_width <= i_data_width;
              mem_address    <= i_address;
              mem_data_in    <= i_data_in;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            last_grant_q <= grant_q;
            if (grant_q == GRANT_D) begin
              d_mem_ready <= 1'b1;
              if (!mem_we) d_data_out <= mem_data_out;
            end else begin
              i_mem_ready <= 1'b1;
              if (!mem_we) i_data_out <= mem_data_out;
            end
          end else if (timeout_hit) begin
            mem_req      <= 1'b0;
            last_grant_q <= grant_q;
            if (grant_q == GRANT_D) begin
              d_mem_ready <= 1'b1;
              d_data_out  <= BUS_ERR_DATA;
            end else begin
              i_mem_ready <= 1'b1;
              i_data_out  <= BUS_ERR_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a target model acks after a
// programmable delay, a scoreboard holds the expected bus transactions in
// grant order and the expected data_out per port, popped as the DUT
// completes them.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read_enable, i_write_enable;
  logic [1:0]  i_data_width;
  logic [31:0] i_address, i_data_in, i_data_out;
  logic        i_mem_ready;
  logic        d_read_enable, d_write_enable;
  logic [1:0]  d_data_width;
  logic [31:0] d_address, d_data_in, d_data_out;
  logic        d_mem_ready;
  logic        mem_req, mem_we;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_ack;
  logic        grant_d, err;

  bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_read_enable(i_read_enable), .i_write_enable(i_write_enable),
    .i_data_width(i_data_width), .i_address(i_address), .i_data_in(i_data_in),
    .i_data_out(i_data_out), .i_mem_ready(i_mem_ready),
    .d_read_enable(d_read_enable), .d_write_enable(d_write_enable),
    .d_data_width(d_data_width), .d_address(d_address), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_mem_ready(d_mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_data_width(mem_data_width),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ack(mem_ack),
    .grant_d(grant_d), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gd;
    logic        we;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] i_rdy_q[$];
  logic [31:0] d_rdy_q[$];
  logic [31:0] i_model = 32'd0;
  logic [31:0] d_model = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rdy_cyc = -1;
  bit gap_en = 1'b0;
  int exp_gap = 3;
  bit tgt_en = 1'b1;
  int ack_delay = 0;
  int wait_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h10) return 32'h1234_5678;
    return (a ^ 32'hA5A5_0000) + 32'd1;
  endfunction

  function automatic void push_bus(input logic gd, input logic we, input logic [1:0] w,
                                   input logic [31:0] a, input logic [31:0] wd);
    bus_exp_t e;
    e.gd = gd; e.we = we; e.w = w; e.a = a; e.wd = wd;
    bus_q.push_back(e);
  endfunction

  // Ready/data_out scoreboard and target model, both on the falling edge.
  always @(negedge clk) begin
    bus_exp_t e;
    cyc++;
    if (i_mem_ready || d_mem_ready) begin
      check_eq("ready_exclusive", 32'(i_mem_ready & d_mem_ready), 32'd0);
      if (gap_en && last_rdy_cyc >= 0) check_eq("ready_gap", 32'(cyc - last_rdy_cyc), 32'(exp_gap));
      last_rdy_cyc = cyc;
    end
    if (!gap_en) last_rdy_cyc = -1;
    if (i_mem_ready) begin
      if (i_rdy_q.size() == 0) check_eq("i_ready_unexpected", 32'(i_rdy_q.size()), 32'd1);
      else check_eq("i_data_out", i_data_out, i_rdy_q.pop_front());
    end
    if (d_mem_ready) begin
      if (d_rdy_q.size() == 0) check_eq("d_ready_unexpected", 32'(d_rdy_q.size()), 32'd1);
      else check_eq("d_data_out", d_data_out, d_rdy_q.pop_front());
    end
    mem_ack = 1'b0;
    if (mem_req && tgt_en) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack      = 1'b1;
        mem_data_out = rdata_for(mem_address);
        wait_cnt     = 0;
        if (bus_q.size() == 0) begin
          check_eq("bus_unexpected", 32'(bus_q.size()), 32'd1);
        end else begin
          e = bus_q.pop_front();
          check_eq("bus_grant_d", 32'(grant_d), 32'(e.gd));
          check_eq("bus_we", 32'(mem_we), 32'(e.we));
          check_eq("bus_width", 32'(mem_data_width), 32'(e.w));
          check_eq("bus_addr", mem_address, e.a);
          check_eq("bus_wdata", mem_data_in, e.wd);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // One requester transaction: present, wait (bounded) for ready, then drop.
  task automatic xact(input bit port_d, input bit re, input bit we, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] wd, input bit tmo);
    int n;
    if (port_d) begin
      if (tmo) d_model = 32'hDEAD_BEEF;
      else if (!we) d_model = rdata_for(a);
      d_rdy_q.push_back(d_model);
      d_read_enable = re; d_write_enable = we; d_data_width = w; d_address = a; d_data_in = wd;
    end else begin
      if (tmo) i_model = 32'hDEAD_BEEF;
      else if (!we) i_model = rdata_for(a);
      i_rdy_q.push_back(i_model);
      i_read_enable = re; i_write_enable = we; i_data_width = w; i_address = a; i_data_in = wd;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port_d ? d_mem_ready : i_mem_ready) && n < 300);
    check_eq(port_d ? "d_ready_seen" : "i_ready_seen", 32'(n < 300), 32'd1);
    if (port_d) begin d_read_enable = 1'b0; d_write_enable = 1'b0; end
    else begin i_read_enable = 1'b0; i_write_enable = 1'b0; end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_mem_req"}, 32'(mem_req), 32'd0);
    check_eq({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({pfx, "_mem_width"}, 32'(mem_data_width), 32'd0);
    check_eq({pfx, "_mem_addr"}, mem_address, 32'd0);
    check_eq({pfx, "_mem_wdata"}, mem_data_in, 32'd0);
    check_eq({pfx, "_i_data_out"}, i_data_out, 32'd0);
    check_eq({pfx, "_d_data_out"}, d_data_out, 32'd0);
    check_eq({pfx, "_readies"}, 32'({i_mem_ready, d_mem_ready}), 32'd0);
    check_eq({pfx, "_grant_d"}, 32'(grant_d), 32'd0);
    check_eq({pfx, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_model = 32'd0;
    d_model = 32'd0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    i_read_enable = 0; i_write_enable = 0; i_data_width = 0; i_address = 0; i_data_in = 0;
    d_read_enable = 0; d_write_enable = 0; d_data_width = 0; d_address = 0; d_data_in = 0;
    mem_data_out = 0; mem_ack = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Single read on the instruction port, ack two cycles into ACCESS.
    ack_delay = 2;
    push_bus(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    fork
      xact(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
      begin
        @(negedge clk);
        check_eq("t1_req_latency", 32'(mem_req), 32'd1);
        check_eq("t1_addr", mem_address, 32'h10);
        check_eq("t1_we", 32'(mem_we), 32'd0);
      end
    join
    repeat (3) @(negedge clk);
    check_eq("t1_i_data_hold", i_data_out, 32'h1234_5678);

    // Simultaneous requests right after reset: D wins, I follows 3+k later.
    pulse_reset();
    ack_delay = 1; exp_gap = 4; gap_en = 1'b1;
    push_bus(1'b1, 1'b1, 2'd3, 32'h100, 32'hCAFE_F00D);
    push_bus(1'b0, 1'b0, 2'd1, 32'h20, 32'h0);
    fork
      xact(1'b1, 1'b0, 1'b1, 2'd3, 32'h100, 32'hCAFE_F00D, 1'b0);
      xact(1'b0, 1'b1, 1'b0, 2'd1, 32'h20, 32'h0, 1'b0);
    join
    gap_en = 1'b0;
    repeat (3) @(negedge clk);

    // Continuous contention, zero-wait target: D, I, D, I ... every 3 cycles.
    ack_delay = 0; exp_gap = 3; gap_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_bus(1'b1, k[0], 2'(k), 32'h1000 + 32'(k * 4), 32'hD000_0000 + 32'(k));
      push_bus(1'b0, (k == 1), 2'(3 - k), 32'h2000 + 32'(k * 4), 32'h1000_0000 + 32'(k));
    end
    fork
      begin
        for (int k = 0; k < 4; k++)
          xact(1'b1, 1'b1, k[0], 2'(k), 32'h1000 + 32'(k * 4), 32'hD000_0000 + 32'(k), 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++)
          xact(1'b0, 1'b1, (k == 1), 2'(3 - k), 32'h2000 + 32'(k * 4), 32'h1000_0000 + 32'(k), 1'b0);
      end
    join
    gap_en = 1'b0;
    check_eq("t3_bus_drained", 32'(bus_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    // Reset in the middle of an access: request dropped, no ready pulse.
    tgt_en = 1'b0;
    d_read_enable = 1'b1; d_address = 32'h300; d_data_width = 2'd2;
    repeat (3) @(negedge clk);
    check_eq("t4_req_before", 32'(mem_req), 32'd1);
    check_eq("t4_grant_d_before", 32'(grant_d), 32'd1);
    reset = 1'b1;
    d_read_enable = 1'b0;
    @(negedge clk);
    check_reset_vals("t4");
    reset = 1'b0;
    i_model = 32'd0; d_model = 32'd0;
    repeat (6) @(negedge clk);
    check_eq("t4_req_after", 32'(mem_req), 32'd0);
    tgt_en = 1'b1;

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Unacknowledged D read aborts after TMO ACCESS cycles with the error word.
    tgt_en = 1'b0;
    fork
      xact(1'b1, 1'b1, 1'b0, 2'd2, 32'h400, 32'h0, 1'b1);
      begin
        n = 0;
        for (int c = 0; c < 100 && !d_mem_ready; c++) begin
          @(negedge clk);
          if (mem_req) n++;
        end
        check_eq("t5_req_cycles", 32'(n), 32'(TMO));
      end
    join
    check_eq("t5_err_set", 32'(err), 32'd1);
    tgt_en = 1'b1;
    ack_delay = 1;
    push_bus(1'b0, 1'b0, 2'd2, 32'h500, 32'h0);
    xact(1'b0, 1'b1, 1'b0, 2'd2, 32'h500, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t5_err_sticky", 32'(err), 32'd1);
    check_eq("t5_d_data_hold", d_data_out, 32'hDEAD_BEEF);
`else
    n = 0;
    check_eq("err_tied_low", 32'(err), 32'(n));
`endif

    check_eq("bus_all_drained", 32'(bus_q.size()), 32'd0);
    check_eq("ready_all_drained", 32'(i_rdy_q.size() + d_rdy_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
